// File: rtl/xulie_serial_gen.sv
// xulie_serial_gen: MSB-first serial pattern generator with clock divider and seamless repeat mode
module xulie_serial_gen #(
  parameter int WIDTH = 16,
  parameter int DIV = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     rpt,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     Dout,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);
  localparam int BW = $clog2(WIDTH);
  localparam logic IDLE = 1'b0;
  localparam logic SHIFT = 1'b1;
  logic state;
  logic [WIDTH-1:0] cap, shreg;
  logic [7:0] div_cnt;
  logic last_div, last_bit;
  assign last_div = div_cnt == 8'(DIV - 1);
  assign last_bit = bit_cnt == BW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cap <= '0;
      shreg <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      Dout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          cap <= data_in;
          shreg <= data_in;
          Dout <= data_in[WIDTH-1];
          busy <= 1'b1;
          bit_cnt <= '0;
          div_cnt <= '0;
          state <= SHIFT;
        end
      end else if (!last_div) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        if (!last_bit) begin
          shreg <= shreg << 1;
          Dout <= shreg[WIDTH-2];
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          done <= 1'b1;
          bit_cnt <= '0;
          if (rpt) begin
            shreg <= cap;
            Dout <= cap[WIDTH-1];
          end else begin
            Dout <= 1'b0;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_xulie_serial_gen.sv
// tb_xulie_serial_gen: checks three generator configurations against a frame-position model
module tb_xulie_serial_gen;
  logic clk = 1'b0;
  logic reset, start, rpt;
  logic [15:0] data_in;
  logic d[3], b[3], dn[3];
  logic [3:0] bc0, bc1;
  logic [0:0] bc2;
  int total = 0, bad = 0;
  bit chk = 1'b0;
  int wv[3] = '{16, 16, 2};
  int dv[3] = '{1, 3, 1};
  logic [15:0] cm[3];
  int tm[3];
  bit am[3], dm[3];
  always #5 clk = ~clk;
  xulie_serial_gen #(.WIDTH(16), .DIV(1)) u1 (.clk(clk), .reset(reset), .start(start), .rpt(rpt),
    .data_in(data_in), .Dout(d[0]), .busy(b[0]), .done(dn[0]), .bit_cnt(bc0));
  xulie_serial_gen #(.WIDTH(16), .DIV(3)) u3 (.clk(clk), .reset(reset), .start(start), .rpt(rpt),
    .data_in(data_in), .Dout(d[1]), .busy(b[1]), .done(dn[1]), .bit_cnt(bc1));
  xulie_serial_gen #(.WIDTH(2), .DIV(1)) u2 (.clk(clk), .reset(reset), .start(start), .rpt(rpt),
    .data_in(data_in[1:0]), .Dout(d[2]), .busy(b[2]), .done(dn[2]), .bit_cnt(bc2));
  task automatic c(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  // Model tracks clocks elapsed within the current frame; outputs follow from that position.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        am[i] = 0; tm[i] = 0; dm[i] = 0;
      end else if (!am[i]) begin
        dm[i] = 0;
        if (start) begin
          am[i] = 1; tm[i] = 0;
          cm[i] = (i == 2) ? {14'b0, data_in[1:0]} : data_in;
        end
      end else if (tm[i] == wv[i] * dv[i] - 1) begin
        dm[i] = 1; tm[i] = 0; am[i] = rpt;
      end else begin
        tm[i]++; dm[i] = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (chk) begin
      for (int i = 0; i < 3; i++) begin
        int bi, bcv;
        bi = tm[i] / dv[i];
        bcv = (i == 0) ? int'(bc0) : (i == 1) ? int'(bc1) : int'(bc2);
        c($sformatf("dout[%0d]", i), d[i], am[i] ? cm[i][wv[i]-1-bi] : 0);
        c($sformatf("busy[%0d]", i), b[i], am[i]);
        c($sformatf("done[%0d]", i), dn[i], dm[i]);
        c($sformatf("bit_cnt[%0d]", i), bcv, am[i] ? bi : 0);
      end
    end
  end
  task automatic pulse(input logic [15:0] v);
    data_in = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    logic [15:0] got, pat;
    int cnt, mis, ones, bsy_low;
    reset = 1'b0; start = 1'b1; rpt = 1'b0; data_in = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      chk = 1'b1;
      c("rst_dout", d[0], 0); c("rst_busy", b[0], 0); c("rst_done", dn[0], 0);
    end
    reset = 1'b1; start = 1'b0;
    cnt = 0;
    repeat (5) begin @(negedge clk); cnt += b[0] + b[1] + b[2]; end
    c("post_rst_idle", cnt, 0);
    pulse(16'h2FBA);
    got = '0; cnt = 0;
    for (int i = 0; i < 16; i++) begin
      got[15-i] = d[0]; cnt += dn[0];
      @(negedge clk);
    end
    pat = 16'h2FBA;
    c("2fba_bits", got, pat);
    c("2fba_early_done", cnt, 0);
    c("2fba_done", dn[0], 1);
    c("2fba_busy_after", b[0], 0);
    cnt = 0;
    for (int i = 3; i < 16; i++) if (got[18-i -: 4] == 4'b1110) cnt++;
    c("2fba_detections", cnt, 2);
    repeat (40) @(negedge clk);
    pulse(16'h8001);
    mis = 0; cnt = 0;
    for (int i = 0; i < 48; i++) begin
      if (d[1] !== ((i < 3 || i >= 45) ? 1'b1 : 1'b0)) mis++;
      cnt += dn[1];
      if (i == 10) c("div3_bitcnt_i10", bc1, 3);
      if (i == 44) c("div3_bitcnt_i44", bc1, 14);
      @(negedge clk);
    end
    c("8001_shape", mis, 0);
    c("8001_early_done", cnt, 0);
    c("8001_done", dn[1], 1);
    repeat (10) @(negedge clk);
    rpt = 1'b1;
    pulse(16'h000E);
    pat = 16'h000E; mis = 0; cnt = 0; bsy_low = 0;
    for (int i = 0; i < 40; i++) begin
      if (d[0] !== pat[15 - (i % 16)]) mis++;
      cnt += dn[0]; bsy_low += !b[0];
      @(negedge clk);
    end
    c("rep_stream", mis, 0);
    c("rep_done_count", cnt, 2);
    c("rep_busy_low", bsy_low, 0);
    rpt = 1'b0;
    repeat (8) @(negedge clk);
    c("rep_end_done", dn[0], 1);
    c("rep_end_busy", b[0], 0);
    repeat (5) @(negedge clk);
    pulse(16'h0000);
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      ones += d[0];
      if (i == 5) begin data_in = 16'hFFFF; start = 1'b1; end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
    c("ignored_start_ones", ones, 0);
    c("ignored_start_done", dn[0], 1);
    repeat (50) @(negedge clk);
    data_in = 16'h8000; start = 1'b1;
    repeat (17) @(negedge clk);
    c("held_start_gap_busy", b[0], 0);
    @(negedge clk);
    c("held_start_restart", b[0], 1);
    c("held_start_dout", d[0], 1);
    start = 1'b0;
    repeat (60) @(negedge clk);
    pulse(16'hFFFF);
    repeat (7) @(negedge clk);
    c("pre_abort_dout", d[0], 1);
    reset = 1'b0;
    @(negedge clk);
    c("abort_dout", d[0], 0); c("abort_busy", b[0], 0); c("abort_busy3", b[1], 0);
    reset = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); cnt += dn[0] + dn[1] + dn[2]; end
    c("abort_no_done", cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xulie_serial_gen.md
Name: xulie_serial_gen

Overview:
Serial bit-stream generator, the transmit end of the xulie_1110 sequence detectors. It loads a WIDTH-bit pattern word and shifts it out MSB-first on Dout, one bit per bit period. Dout is shaped so it can drive the Din input of xulie_1110_Moore / xulie_1110_Mealy directly. It is used as the stimulus source for detector self-checks on the board and in regression benches.

Parameters:
WIDTH  16  pattern length in bits (2..32)
DIV    1   clocks per output bit (1..255); bit period = DIV clk cycles

Ports:
clk      input   1                clock; all logic on rising edge
reset    input   1                synchronous reset, active-low (reset=0 clears on next rising clk edge)
start    input   1                request one frame; sampled only in IDLE
repeat   input   1                continuous mode; sampled at the end of each frame
data_in  input   WIDTH            pattern word; captured on accepted start
Dout     output  1                serial data, registered
busy     output  1                1 while a frame is being shifted
done     output  1                one-clock pulse at the end of each frame
bit_cnt  output  $clog2(WIDTH)    index of the bit currently on Dout (0 = MSB)

Behaviour:
- Reset (reset=0 at a clk edge) forces:
  - state=IDLE, Dout=0, busy=0, done=0, bit_cnt=0.
  - Shift register, capture register and divider counter cleared.
  - Reset takes priority over every other input.
- Reset mid-frame aborts the frame immediately. No done pulse is produced. Dout=0 from that edge on.
- States: IDLE, SHIFT (2-state FSM plus datapath).
- IDLE, start=1 at edge k:
  - cap<=data_in; shreg<=data_in; Dout<=data_in[WIDTH-1] at edge k (latency 1 clk from start sample).
  - busy<=1, bit_cnt<=0, div_cnt<=0, state<=SHIFT.
- IDLE, start=0: all outputs hold their reset values; data_in is ignored.
- SHIFT:
  - div_cnt counts 0..DIV-1. Each Dout value is held exactly DIV clocks.
  - When div_cnt=DIV-1 and bit_cnt<WIDTH-1: shift left, Dout<=next bit, bit_cnt+1, div_cnt<=0.
- End of frame (div_cnt=DIV-1 and bit_cnt=WIDTH-1):
  - done<=1 for exactly one clock.
  - repeat=1: reload shreg<=cap, Dout<=cap[WIDTH-1], bit_cnt<=0, busy stays 1, state stays SHIFT. There is no gap bit; the stream is seamless.
  - repeat=0: Dout<=0, busy<=0, state<=IDLE.
- start while busy=1 is ignored. data_in changes while busy=1 are ignored; cap is used for repeats.
- start=1 on the same edge that returns to IDLE is ignored. A new frame starts no earlier than the following edge.
- Frame length: WIDTH*DIV clocks from the first Dout bit to the done edge.
- busy goes high on the start edge and low on the done edge (repeat=0).
- done is never asserted in IDLE and never on two consecutive clocks when DIV>1.
- WIDTH=2, DIV=1 must work. In that case done pulses every 2 clocks in repeat mode.

Test Plan:
- Reset held low 3 clks with start=1 and data_in=16'hFFFF -> Dout=0, busy=0, done=0 throughout; no frame after reset deasserts unless start is re-asserted.
- DIV=1, data_in=16'h2FBA, start pulse -> Dout=0,0,1,0,1,1,1,1,1,0,1,1,1,0,1,0 on 16 consecutive clocks; done high on clock 16 only; busy low after. Driving xulie_1110_Moore gives exactly 2 Dout detections (ending at bits 9 and 13).
- DIV=3, data_in=16'h8001 -> Dout=1 for 3 clks, then 0 for 42 clks, then 1 for 3 clks; done at clock 48; bit_cnt steps every 3 clks.
- repeat=1, DIV=1, data_in=16'h000E -> continuous ...0000000000001110 stream with no gap; done every 16 clocks; busy stays 1. Dropping repeat before the frame end -> return to IDLE after the current frame.
- start re-pulsed at bit 5 with data_in=16'hFFFF during a 16'h0000 frame -> ignored; all 16 bits are 0.
- reset=0 at bit 7 of a 16'hFFFF frame -> Dout=0 and busy=0 on that edge; no done pulse.
